// File: rtl/rgb_yuv_csc.sv
// Forward BT.601 RGB -> YCbCr 4:4:4 converter, LANES pixels per clock.
// Fixed three-register pipeline; sync/DE delayed by a matching shift register.
module rgb_yuv_csc #(
  parameter int LANES   = 4,
  parameter bit LIMITED = 1'b1
) (
  input  logic                 vid_clk,
  input  logic                 vid_rst,
  input  logic [8*LANES-1:0]   R,
  input  logic [8*LANES-1:0]   G,
  input  logic [8*LANES-1:0]   B,
  input  logic                 TPG_HS,
  input  logic                 TPG_VS,
  input  logic                 TPG_DE,
  output logic                 HS,
  output logic                 VS,
  output logic                 DE,
  output logic [8*LANES-1:0]   Y,
  output logic [8*LANES-1:0]   U,
  output logic [8*LANES-1:0]   V,
  output logic [24*LANES-1:0]  data_yuv
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int STAGES = 3;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 2;

  // Coefficient magnitudes; signs are applied in the summing stage.
  localparam logic [COEF_W-1:0] C_YR = LIMITED ? 8'd66  : 8'd77;
  localparam logic [COEF_W-1:0] C_YG = LIMITED ? 8'd129 : 8'd150;
  localparam logic [COEF_W-1:0] C_YB = LIMITED ? 8'd25  : 8'd29;
  localparam logic [COEF_W-1:0] C_UR = LIMITED ? 8'd38  : 8'd43;
  localparam logic [COEF_W-1:0] C_UG = LIMITED ? 8'd74  : 8'd85;
  localparam logic [COEF_W-1:0] C_UB = LIMITED ? 8'd112 : 8'd128;
  localparam logic [COEF_W-1:0] C_VR = LIMITED ? 8'd112 : 8'd128;
  localparam logic [COEF_W-1:0] C_VG = LIMITED ? 8'd94  : 8'd107;
  localparam logic [COEF_W-1:0] C_VB = LIMITED ? 8'd18  : 8'd21;

  localparam logic signed [SUM_W-1:0] OFS_Y   = LIMITED ? 18'sd4224 : 18'sd128;
  localparam logic signed [SUM_W-1:0] OFS_C   = 18'sd32896;
  localparam logic signed [SUM_W-1:0] SAT_MAX = 18'sd255;

  function automatic logic signed [SUM_W-1:0] ext_prod(input logic [PROD_W-1:0] p);
    return $signed({2'b00, p});
  endfunction

  function automatic logic [DATA_W-1:0] sat_q8(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] q;
    q = s >>> 8;
    if (q[SUM_W-1])
      sat_q8 = '0;
    else if (q > SAT_MAX)
      sat_q8 = '1;
    else
      sat_q8 = q[DATA_W-1:0];
  endfunction

  logic hs_p0, hs_p1, hs_p2;
  logic vs_p0, vs_p1, vs_p2;
  logic vld_p0, vld_p1, vld_p2;

  always_ff @(posedge vid_clk or posedge vid_rst) begin
    if (vid_rst) begin
      hs_p0  <= 1'b0;
      hs_p1  <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p0  <= 1'b0;
      vs_p1  <= 1'b0;
      vs_p2  <= 1'b0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      hs_p0  <= TPG_HS;
      hs_p1  <= hs_p0;
      hs_p2  <= hs_p1;
      vs_p0  <= TPG_VS;
      vs_p1  <= vs_p0;
      vs_p2  <= vs_p1;
      vld_p0 <= TPG_DE;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  assign HS = hs_p2;
  assign VS = vs_p2;
  assign DE = vld_p2;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] r, g, b;
    logic [PROD_W-1:0] yr_p0, yg_p0, yb_p0;
    logic [PROD_W-1:0] ur_p0, ug_p0, ub_p0;
    logic [PROD_W-1:0] vr_p0, vg_p0, vb_p0;
    logic signed [SUM_W-1:0] sum_y_p1, sum_u_p1, sum_v_p1;
    logic [DATA_W-1:0] y_p2, u_p2, v_p2;

    assign r = R[DATA_W*i +: DATA_W];
    assign g = G[DATA_W*i +: DATA_W];
    assign b = B[DATA_W*i +: DATA_W];

    always_ff @(posedge vid_clk or posedge vid_rst) begin
      if (vid_rst) begin
        yr_p0    <= '0;
        yg_p0    <= '0;
        yb_p0    <= '0;
        ur_p0    <= '0;
        ug_p0    <= '0;
        ub_p0    <= '0;
        vr_p0    <= '0;
        vg_p0    <= '0;
        vb_p0    <= '0;
        sum_y_p1 <= '0;
        sum_u_p1 <= '0;
        sum_v_p1 <= '0;
        y_p2     <= '0;
        u_p2     <= '0;
        v_p2     <= '0;
      end else begin
        // Stage p0: unsigned 8x8 product magnitudes.
        yr_p0    <= r * C_YR;
        yg_p0    <= g * C_YG;
        yb_p0    <= b * C_YB;
        ur_p0    <= r * C_UR;
        ug_p0    <= g * C_UG;
        ub_p0    <= b * C_UB;
        vr_p0    <= r * C_VR;
        vg_p0    <= g * C_VG;
        vb_p0    <= b * C_VB;
        // Stage p1: signed sums with rounding term and bias folded in.
        sum_y_p1 <= ext_prod(yr_p0) + ext_prod(yg_p0) + ext_prod(yb_p0) + OFS_Y;
        sum_u_p1 <= ext_prod(ub_p0) - ext_prod(ur_p0) - ext_prod(ug_p0) + OFS_C;
        sum_v_p1 <= ext_prod(vr_p0) - ext_prod(vg_p0) - ext_prod(vb_p0) + OFS_C;
        // Stage p2: drop the Q8 fraction and saturate to 8 bits.
        y_p2     <= sat_q8(sum_y_p1);
        u_p2     <= sat_q8(sum_u_p1);
        v_p2     <= sat_q8(sum_v_p1);
      end
    end

    assign Y[DATA_W*i +: DATA_W]       = y_p2;
    assign U[DATA_W*i +: DATA_W]       = u_p2;
    assign V[DATA_W*i +: DATA_W]       = v_p2;
    assign data_yuv[3*DATA_W*i +: 3*DATA_W] = {y_p2, u_p2, v_p2};
  end

endmodule

// File: tb/tb_rgb_yuv_csc.sv
// Scoreboard bench for rgb_yuv_csc: limited- and full-range instances share stimulus.
module tb_rgb_yuv_csc;

  logic        vid_clk = 1'b0;
  logic        vid_rst = 1'b0;
  logic [31:0] R = '0, G = '0, B = '0;
  logic        TPG_HS = 1'b0, TPG_VS = 1'b0, TPG_DE = 1'b0;

  logic        hs_l, vs_l, de_l, hs_f, vs_f, de_f;
  logic [31:0] y_l, u_l, v_l, y_f, u_f, v_f;
  logic [95:0] d_l, d_f;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 vid_clk = ~vid_clk;

  rgb_yuv_csc #(.LANES(4), .LIMITED(1'b1)) dut_lim (
    .vid_clk(vid_clk), .vid_rst(vid_rst), .R(R), .G(G), .B(B),
    .TPG_HS(TPG_HS), .TPG_VS(TPG_VS), .TPG_DE(TPG_DE),
    .HS(hs_l), .VS(vs_l), .DE(de_l), .Y(y_l), .U(u_l), .V(v_l), .data_yuv(d_l)
  );

  rgb_yuv_csc #(.LANES(4), .LIMITED(1'b0)) dut_full (
    .vid_clk(vid_clk), .vid_rst(vid_rst), .R(R), .G(G), .B(B),
    .TPG_HS(TPG_HS), .TPG_VS(TPG_VS), .TPG_DE(TPG_DE),
    .HS(hs_f), .VS(vs_f), .DE(de_f), .Y(y_f), .U(u_f), .V(v_f), .data_yuv(d_f)
  );

  typedef struct {
    logic [31:0] yl, ul, vl, yf, uf, vf;
    logic [95:0] pl, pf;
    logic        hs, vs, de;
    logic        use_k;
    logic [23:0] kl, kf;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat(input int s);
    int q;
    q = s >>> 8;
    if (q < 0) return 8'd0;
    if (q > 255) return 8'd255;
    return 8'(q);
  endfunction

  function automatic logic [23:0] yuv_ref(input bit lim, input logic [7:0] r, g, b);
    int ri, gi, bi, ys, us, vs;
    ri = int'(r); gi = int'(g); bi = int'(b);
    if (lim) begin
      ys = 66*ri + 129*gi + 25*bi + 4224;
      us = -38*ri - 74*gi + 112*bi + 32896;
      vs = 112*ri - 94*gi - 18*bi + 32896;
    end else begin
      ys = 77*ri + 150*gi + 29*bi + 128;
      us = -43*ri - 85*gi + 128*bi + 32896;
      vs = 128*ri - 107*gi - 21*bi + 32896;
    end
    return {sat(ys), sat(us), sat(vs)};
  endfunction

  function automatic exp_t build_exp(input logic [31:0] r, g, b, input logic hs, vs, de);
    exp_t e;
    logic [23:0] l, f;
    e = '{default: '0};
    for (int i = 0; i < 4; i++) begin
      l = yuv_ref(1'b1, r[8*i +: 8], g[8*i +: 8], b[8*i +: 8]);
      f = yuv_ref(1'b0, r[8*i +: 8], g[8*i +: 8], b[8*i +: 8]);
      e.yl[8*i +: 8] = l[23:16]; e.ul[8*i +: 8] = l[15:8]; e.vl[8*i +: 8] = l[7:0];
      e.yf[8*i +: 8] = f[23:16]; e.uf[8*i +: 8] = f[15:8]; e.vf[8*i +: 8] = f[7:0];
      e.pl[24*i +: 24] = l;
      e.pf[24*i +: 24] = f;
    end
    e.hs = hs; e.vs = vs; e.de = de; e.chk_data = 1'b1;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    chk("HS_lim", 96'(hs_l), 96'(e.hs));
    chk("VS_lim", 96'(vs_l), 96'(e.vs));
    chk("DE_lim", 96'(de_l), 96'(e.de));
    chk("HS_full", 96'(hs_f), 96'(e.hs));
    chk("VS_full", 96'(vs_f), 96'(e.vs));
    chk("DE_full", 96'(de_f), 96'(e.de));
    if (e.chk_data) begin
      chk("Y_lim", 96'(y_l), 96'(e.yl));
      chk("U_lim", 96'(u_l), 96'(e.ul));
      chk("V_lim", 96'(v_l), 96'(e.vl));
      chk("yuv_lim", d_l, e.pl);
      chk("Y_full", 96'(y_f), 96'(e.yf));
      chk("U_full", 96'(u_f), 96'(e.uf));
      chk("V_full", 96'(v_f), 96'(e.vf));
      chk("yuv_full", d_f, e.pf);
    end
    if (e.use_k) begin
      chk("lane0_lim_const", 96'(d_l[23:0]), 96'(e.kl));
      chk("lane0_full_const", 96'(d_f[23:0]), 96'(e.kf));
    end
  endtask

  task automatic step_k(input logic [31:0] r, g, b, input logic hs, vs, de,
                        input logic use_k, input logic [23:0] kl, kf);
    exp_t e;
    @(posedge vid_clk);
    #1;
    if (sb.size() == 3) compare(sb.pop_front());
    else chk("scoreboard_depth", 96'(sb.size()), 96'(3));
    R = r; G = g; B = b; TPG_HS = hs; TPG_VS = vs; TPG_DE = de;
    e = build_exp(r, g, b, hs, vs, de);
    e.use_k = use_k; e.kl = kl; e.kf = kf;
    sb.push_back(e);
  endtask

  task automatic step(input logic [31:0] r, g, b, input logic hs, vs, de);
    step_k(r, g, b, hs, vs, de, 1'b0, 24'h0, 24'h0);
  endtask

  // Asserted between edges; outputs must clear with no clock edge.
  task automatic do_reset();
    exp_t z;
    #2;
    vid_rst = 1'b1;
    R = '0; G = '0; B = '0; TPG_HS = 1'b0; TPG_VS = 1'b0; TPG_DE = 1'b0;
    #1;
    chk("rst_yuv_lim", d_l, 96'h0);
    chk("rst_yuv_full", d_f, 96'h0);
    chk("rst_Y_lim", 96'(y_l), 96'h0);
    chk("rst_UV_full", 96'({u_f, v_f}), 96'h0);
    chk("rst_sync_lim", 96'({hs_l, vs_l, de_l}), 96'h0);
    chk("rst_sync_full", 96'({hs_f, vs_f, de_f}), 96'h0);
    @(posedge vid_clk);
    #3;
    vid_rst = 1'b0;
    sb.delete();
    z = '{default: '0};
    z.chk_data = 1'b1;
    sb.push_back(z);
    sb.push_back(build_exp('0, '0, '0, 1'b0, 1'b0, 1'b0));
    sb.push_back(build_exp('0, '0, '0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pr, pg, pb;
    do_reset();

    step_k('1, '1, '1, 1'b0, 1'b0, 1'b1, 1'b1, 24'hEB8080, 24'hFF8080);
    step_k('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h108080, 24'h008080);
    step_k(32'h0000_00FF, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h525AF0, 24'h4D55FF);
    step_k('0, '0, '1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h29F06E, 24'h1DFF6B);

    step(32'h1020_3040, 32'h5060_7080, 32'h90A0_B0C0, 1'b0, 1'b1, 1'b1);
    step(32'hC0B0_A090, 32'h8070_6050, 32'h4030_2010, 1'b1, 1'b0, 1'b0);
    step(32'hFF00_FF00, 32'h00FF_00FF, 32'h8080_8080, 1'b1, 1'b0, 1'b1);
    step(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 1'b0, 1'b1, 1'b1);

    for (int k = 0; k < 40; k++) begin
      pr = $urandom; pg = $urandom; pb = $urandom;
      step(pr, pg, pb, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    do_reset();
    for (int k = 0; k < 12; k++) begin
      pr = $urandom; pg = $urandom; pb = $urandom;
      step(pr, pg, pb, 1'(k[1]), 1'(k[2]), 1'b1);
    end

    for (int k = 0; k < 3; k++) step('0, '0, '0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_yuv_csc.md
Name: rgb_yuv_csc

Overview:
- Forward colour-space converter: 4-lane 8-bit RGB in, YCbCr 4:4:4 out, one pixel per lane per clock.
- Sits in the video path ahead of YUV-domain processing or transmission; inverse of the downstream YUV-to-RGB stage.
- Fixed 3-cycle pipeline; HS/VS/DE are delayed to match the pixel data exactly.

Parameters:
- LANES, 4, pixels per clock; each lane is 8 bits wide.
- LIMITED, 1, 1 = BT.601 limited range (Y 16..235, C 16..240); 0 = BT.601 full range (0..255).

Ports:
- vid_clk  in  1  video clock.
- vid_rst  in  1  reset, asynchronous, active-high; clears all pipeline and sync state.
- R  in  8*LANES  red; lane i = R[8i+:8].
- G  in  8*LANES  green.
- B  in  8*LANES  blue.
- TPG_HS  in  1  input hsync.
- TPG_VS  in  1  input vsync.
- TPG_DE  in  1  input data enable.
- HS  out  1  hsync delayed 3 cycles.
- VS  out  1  vsync delayed 3 cycles.
- DE  out  1  DE delayed 3 cycles.
- Y  out  8*LANES  luma per lane.
- U  out  8*LANES  Cb per lane.
- V  out  8*LANES  Cr per lane.
- data_yuv  out  24*LANES  packed output, lane LANES-1 in the MSBs, each lane packed {Y,U,V}.

Behaviour:
- Reset: all outputs read 0 asynchronously while vid_rst=1; this includes HS/VS/DE. All pipeline registers and the sync shift registers are cleared.
- Coefficients (Q8, signed), selected by LIMITED:
  - LIMITED=1: Y=66R+129G+25B+4224; Cb=-38R-74G+112B+32896; Cr=112R-94G-18B+32896.
  - LIMITED=0: Y=77R+150G+29B+128; Cb=-43R-85G+128B+32896; Cr=128R-107G-21B+32896.
  - The offset constants include the +128 rounding term and the 16/128 bias pre-scaled by 256.
- Pipeline per lane, independent lanes, no stalls, conversion runs every cycle regardless of DE:
  - Stage 1 registers the 9 products, unsigned 8b x 8b magnitude, 16 bits each.
  - Stage 2 registers three signed 18-bit sums, offsets included.
  - Stage 3 applies an arithmetic >>8 and clamps: result <0 gives 0, result >255 gives 255, otherwise bits [15:8]. The result is registered to the outputs.
- Latency: input sampled at edge n appears on Y/U/V at edge n+3. HS/VS/DE use a 3-deep flop shift register, so DE aligns with the corresponding pixel.
- Clamp: only reachable with LIMITED=0. Example: B=255, R=G=0 gives Cb sum 65536, clamped to 255.
- Reset mid-stream: in-flight pixels are discarded. After release, outputs show the converted zeros (black) until real data propagates. The first post-reset input appears 3 cycles after it is sampled. DE stays 0 for the first 3 cycles after release.
- Sync signals pass through without interpretation; no polarity change.

Test Plan:
- LIMITED=1, all lanes R=G=B=255 -> Y=235, U=128, V=128 on every lane, 3 cycles after input.
- LIMITED=1, R=G=B=0 -> Y=16, U=128, V=128; LIMITED=0, same input -> Y=0, U=128, V=128.
- LIMITED=1, lane0 R=255 only, lanes1-3 black -> lane0 Y=82, U=90, V=240; other lanes Y=16, U=128, V=128; data_yuv[23:0]=0x525AF0.
- LIMITED=0, B=255, R=G=0 -> Y=29, U=255 (clamped), V=107.
- Drive TPG_DE pattern 1,0,1,1 with distinct pixels each cycle -> DE reproduces 1,0,1,1 delayed by exactly 3 cycles, each DE=1 cycle carrying its matching converted pixel; HS/VS toggles are likewise delayed by 3 cycles.
- Assert vid_rst between clock edges mid-frame -> all outputs 0 immediately, with no clock edge needed; after deassert, DE=0 for 3 cycles, then follows TPG_DE.
